// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//
// Sequencing controller for the AES MixColumns step. A 128-bit state is
// accepted over a valid/ready handshake, its four columns are run through a
// shared single-column GF(2^8) mixer COLS_PER_CYCLE columns at a time
// (updating the state buffer in place), and the mixed state is presented
// on a valid/ready output. A per-transaction bypass passes the state through
// unmixed for the final AES round.
//
// Byte k of a state (bits [127-8k -: 8]) is row k%4, column k/4.
//
// Parameters:
//   COLS_PER_CYCLE  columns mixed per cycle; 1, 2 or 4.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    block can accept a state (high only in IDLE)
//   in_state   in   128  input state
//   in_bypass  in   1    pass state through unmixed (sampled with in_state)
//   in_inverse in   1    apply InvMixColumns (only with MIX_COLUMNS_INV_EN)
//   out_valid  out  1    out_state valid (high only in HOLD)
//   out_ready  in   1    downstream accepts the output
//   out_state  out  128  mixed state (zero outside HOLD)
//   busy       out  1    FSM is not IDLE
//
// Optional feature:
//   Define MIX_COLUMNS_INV_EN to add the in_inverse port and the
//   InvMixColumns datapath. Without it only forward MixColumns exists.
// ---------------------------------------------------------------------------
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         in_inverse,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MIX  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Column index step; for 4 columns per cycle this truncates to 0, which
    // is harmless because that group is always the last one.
    localparam logic [1:0] COL_STEP       = 2'(COLS_PER_CYCLE);
    // First column of the final group: 3, 2 or 0.
    localparam logic [1:0] LAST_COL_START = 2'(4 - COLS_PER_CYCLE);

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward mix of one column; row 0 sits in bits [31:24].
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  s  [4];
        logic [7:0]  x2 [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2[i] = xtime(s[i]);
        end
        for (int i = 0; i < 4; i++) begin
            res[31-8*i -: 8] = x2[i]
                             ^ (x2[(i+1)%4] ^ s[(i+1)%4])
                             ^ s[(i+2)%4]
                             ^ s[(i+3)%4];
        end
        return res;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse mix of one column with coefficients 0e,0b,0d,09, each built
    // from the 2x/4x/8x multiples obtained by chaining xtime.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  s  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])                         // 0e
                             ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4])        // 0b
                             ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4])        // 0d
                             ^ (x8[(i+3)%4] ^ s[(i+3)%4]);                     // 09
        end
        return res;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,   state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    // Element 3 holds column 0 so the packed view matches in_state directly.
    logic [3:0][31:0]  buf_q,     buf_d;
`ifdef MIX_COLUMNS_INV_EN
    logic              inv_q,     inv_d;
`endif

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        col_idx_d = col_idx_q;
        buf_d     = buf_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d     = inv_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d     = in_state;
                    col_idx_d = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d     = in_inverse;
`endif
                    state_d   = in_bypass ? ST_HOLD : ST_MIX;
                end
            end

            ST_MIX: begin
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    logic [1:0] col;
                    col = col_idx_q + 2'(j);
`ifdef MIX_COLUMNS_INV_EN
                    buf_d[2'd3 - col] = inv_q ? mix_inv(buf_q[2'd3 - col])
                                              : mix_fwd(buf_q[2'd3 - col]);
`else
                    buf_d[2'd3 - col] = mix_fwd(buf_q[2'd3 - col]);
`endif
                end
                if (col_idx_q == LAST_COL_START) begin
                    col_idx_d = 2'd0;
                    state_d   = ST_HOLD;
                end else begin
                    col_idx_d = col_idx_q + COL_STEP;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                col_idx_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            col_idx_q <= 2'd0;
            // NOTE: the state buffer is reset too, so an aborted transaction
            // leaves no stale data behind.
            buf_q     <= '0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            buf_q     <= buf_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q     <= inv_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    // Partial results during MIX are not exposed.
    assign out_state = out_valid ? buf_q : '0;

endmodule

// File: tb/tb_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_seq
//
// Two instances: index 0 with COLS_PER_CYCLE=1, index 1 with
// COLS_PER_CYCLE=4. A reference model (generic GF(2^8) multiply applied to
// the MixColumns matrix) fills an expectation queue per instance at each
// input handshake; one compare process checks every valid output against it.
// Directed tests cover latency, bypass, backpressure and mid-operation
// reset; a randomized phase follows. Define MIX_COLUMNS_INV_EN to include
// the inverse-mode tests.
// ---------------------------------------------------------------------------
module tb_mix_columns_seq;

    localparam logic [127:0] V1     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_MIX = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2     = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] V2_MIX = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
    localparam logic [127:0] V3     = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst        [2];
    logic         in_valid   [2];
    logic         in_ready   [2];
    logic [127:0] in_state   [2];
    logic         in_bypass  [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [127:0] out_state  [2];
    logic         busy       [2];
`ifdef MIX_COLUMNS_INV_EN
    logic         in_inverse [2];
`endif

    logic         rand_mode   [2];
    logic         rnd_ready   [2];
    logic         force_ready [2];

    assign out_ready[0] = rand_mode[0] ? rnd_ready[0] : force_ready[0];
    assign out_ready[1] = rand_mode[1] ? rnd_ready[1] : force_ready[1];

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .in_bypass(in_bypass[0]),
`ifdef MIX_COLUMNS_INV_EN
        .in_inverse(in_inverse[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0])
    );

    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .in_bypass(in_bypass[1]),
`ifdef MIX_COLUMNS_INV_EN
        .in_inverse(in_inverse[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] exp0 [$];
    logic [127:0] exp1 [$];

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic byp,
                                             input logic inv);
        logic [7:0]   b    [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (byp) return st;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int k = 0; k < 16; k++) b[k] = st[127-8*k -: 8];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[j], b[4*c + (r+j)%4]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [127:0] v);
        if (k == 0) exp0.push_back(v);
        else        exp1.push_back(v);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    // Drives one transaction; returns on the falling edge just after the
    // accepting rising edge (i.e. during cycle T+1).
    task automatic send(input int k, input logic [127:0] st, input logic byp,
                        input logic inv);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready[k] && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready[k]) begin
            check($sformatf("send_timeout_%0d", k), {127'b0, in_ready[k]}, 128'd1);
            return;
        end
        in_valid[k]  = 1'b1;
        in_state[k]  = st;
        in_bypass[k] = byp;
`ifdef MIX_COLUMNS_INV_EN
        in_inverse[k] = inv;
`endif
        push_exp(k, ref_mix(st, byp, inv));
        @(negedge clk);
        // Scramble inputs to prove they are only sampled at the handshake.
        in_valid[k]  = 1'b0;
        in_state[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_bypass[k] = 1'($urandom());
`ifdef MIX_COLUMNS_INV_EN
        in_inverse[k] = 1'($urandom());
`endif
    endtask

    // Sends with out_ready high and checks the output latency and width.
    task automatic send_timed(input int k, input logic [127:0] st, input logic byp,
                              input logic inv, input int lat, input string name);
        int n;
        send(k, st, byp, inv);
        n = 1;
        while (!out_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 128'(n), 128'(lat));
        @(negedge clk);
        check({name, "_one_cycle"}, {127'b0, out_valid[k]}, 128'd0);
        check({name, "_ready_after"}, {127'b0, in_ready[k]}, 128'd1);
    endtask

    task automatic wait_empty(input int k);
        int w;
        w = 0;
        while (qsize(k) != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("drain_%0d", k), 128'(qsize(k)), 128'd0);
    endtask

    task automatic rand_run(input int k, input int n);
        logic [127:0] st;
        logic         byp;
        logic         inv;
        for (int i = 0; i < n; i++) begin
            st  = {$urandom(), $urandom(), $urandom(), $urandom()};
            byp = ($urandom_range(0, 3) == 0);
            inv = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv = 1'($urandom());
`endif
            send(k, st, byp, inv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Random output backpressure, changed away from the sampling edge
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        rnd_ready[0] = ($urandom_range(0, 3) != 0);
        rnd_ready[1] = ($urandom_range(0, 2) != 0);
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [127:0] e;
        for (int k = 0; k < 2; k++) begin
            if (!rst[k] && out_valid[k]) begin
                check($sformatf("in_ready_in_hold_%0d", k), {127'b0, in_ready[k]}, 128'd0);
                check($sformatf("busy_in_hold_%0d", k), {127'b0, busy[k]}, 128'd1);
                if (qsize(k) == 0) begin
                    check($sformatf("unexpected_out_%0d", k), {127'b0, out_valid[k]}, 128'd0);
                end else begin
                    e = (k == 0) ? exp0[0] : exp1[0];
                    check($sformatf("out_state_%0d", k), out_state[k], e);
                    if (out_ready[k]) begin
                        if (k == 0) void'(exp0.pop_front());
                        else        void'(exp1.pop_front());
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [127:0] held;
        int           w;

        for (int k = 0; k < 2; k++) begin
            rst[k]         = 1'b1;
            in_valid[k]    = 1'b0;
            in_state[k]    = '0;
            in_bypass[k]   = 1'b0;
            rand_mode[k]   = 1'b0;
            force_ready[k] = 1'b1;
            rnd_ready[k]   = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
            in_inverse[k]  = 1'b0;
`endif
        end

        // Model pinned to literal vectors.
        check("model_fwd_v1", ref_mix(V1, 1'b0, 1'b0), V1_MIX);
        check("model_fwd_v2", ref_mix(V2, 1'b0, 1'b0), V2_MIX);
        check("model_bypass", ref_mix(V3, 1'b1, 1'b0), V3);
        check("model_inv_v1", ref_mix(V1_MIX, 1'b0, 1'b1), V1);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready_%0d", k),  {127'b0, in_ready[k]},  128'd1);
            check($sformatf("rst_out_valid_%0d", k), {127'b0, out_valid[k]}, 128'd0);
            check($sformatf("rst_busy_%0d", k),      {127'b0, busy[k]},      128'd0);
            check($sformatf("rst_out_state_%0d", k), out_state[k],           128'd0);
            rst[k] = 1'b0;
        end

        // Latency and directed vectors.
        send_timed(0, V1, 1'b0, 1'b0, 5, "c1_v1");
        send_timed(1, V2, 1'b0, 1'b0, 2, "c4_v2");
        send_timed(0, V2, 1'b0, 1'b0, 5, "c1_v2");
        send_timed(1, V1, 1'b0, 1'b0, 2, "c4_v1");
        send_timed(0, V3, 1'b1, 1'b0, 1, "c1_bypass");
        send_timed(1, V3, 1'b1, 1'b0, 1, "c4_bypass");

        // Backpressure with upstream holding in_valid during HOLD.
        @(posedge clk);
        #1 force_ready[0] = 1'b0;
        send(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        w = 0;
        while (!out_valid[0] && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_rise", {127'b0, out_valid[0]}, 128'd1);
        held = out_state[0];
        in_valid[0]  = 1'b1;
        in_state[0]  = V1;
        in_bypass[0] = 1'b0;
        push_exp(0, ref_mix(V1, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", {127'b0, out_valid[0]}, 128'd1);
            check("bp_in_ready_low", {127'b0, in_ready[0]}, 128'd0);
            check("bp_state_stable", out_state[0], held);
        end
        @(posedge clk);
        #1 force_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_fall", {127'b0, out_valid[0]}, 128'd0);
        check("bp_in_ready_back", {127'b0, in_ready[0]}, 128'd1);
        check("bp_no_same_cycle_accept", {127'b0, busy[0]}, 128'd0);
        @(negedge clk);
        check("bp_accept_next_cycle", {127'b0, busy[0]}, 128'd1);
        in_valid[0] = 1'b0;
        wait_empty(0);

        // Reset during the second MIX cycle.
        send(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
        @(negedge clk);
        rst[0] = 1'b1;
        exp0.delete();
        @(negedge clk);
        check("mrst_in_ready", {127'b0, in_ready[0]}, 128'd1);
        check("mrst_out_valid", {127'b0, out_valid[0]}, 128'd0);
        check("mrst_busy", {127'b0, busy[0]}, 128'd0);
        check("mrst_out_state", out_state[0], 128'd0);
        rst[0] = 1'b0;
        send_timed(0, V1, 1'b0, 1'b0, 5, "mrst_after");

`ifdef MIX_COLUMNS_INV_EN
        send_timed(0, V1_MIX, 1'b0, 1'b1, 5, "c1_inverse");
        send_timed(1, V1_MIX, 1'b0, 1'b1, 2, "c4_inverse");
        send_timed(0, V3, 1'b1, 1'b1, 1, "c1_bypass_over_inv");
`endif

        // Randomized traffic with random backpressure on both instances.
        @(posedge clk);
        #2;
        rand_mode[0] = 1'b1;
        rand_mode[1] = 1'b1;
        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        @(posedge clk);
        #2;
        rand_mode[0] = 1'b0;
        rand_mode[1] = 1'b0;
        wait_empty(0);
        wait_empty(1);
        repeat (3) @(negedge clk);
        check("final_idle_0", {127'b0, busy[0]}, 128'd0);
        check("final_idle_1", {127'b0, busy[1]}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
